// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one shift-register LIFO between two requesters.
// Each accepted command runs IDLE -> ISSUE -> RESP and returns exactly one response beat.
module stack_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_WIDTH  = $clog2(STACK_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [3:0]              req_op,
    input  logic [2*DATA_WIDTH-1:0] req_data,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    stk_en,
    output logic [1:0]              stk_op,
    output logic [DATA_WIDTH-1:0]   stk_d,
    input  logic [DATA_WIDTH-1:0]   stk_top,
    input  logic                    stk_full,
    input  logic                    stk_empty
);

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    // The pointer width must describe the attached stack; stop elaboration otherwise.
    if (ADDR_WIDTH != $clog2(STACK_DEPTH)) begin : g_param_check
        $error("stack_arbiter: ADDR_WIDTH does not match STACK_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_last_grant;
    logic [1:0]              r_cmd_op;
    logic [DATA_WIDTH-1:0]   r_cmd_data;
    logic                    r_cmd_id;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_err;

    logic                    w_win;
    logic                    w_accept;
    logic [1:0]              w_win_op;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic                    w_err;
    logic                    w_stk_go;
    logic                    w_capture;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        w_win      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_win_op   = w_win ? req_op[3:2] : req_op[1:0];
        w_win_data = w_win ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
    end

    always_comb begin
        w_err     = 1'b1;
        w_stk_go  = 1'b0;
        w_capture = 1'b0;
        case (r_cmd_op)
            OP_PUSH: begin
                w_err    = stk_full;
                w_stk_go = ~stk_full;
            end
            OP_POP: begin
                w_err     = stk_empty;
                w_stk_go  = ~stk_empty;
                w_capture = ~stk_empty;
            end
            OP_PEEK: begin
                w_err     = stk_empty;
                w_capture = ~stk_empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        busy        = 1'b1;
        stk_en      = 1'b0;
        stk_op      = 2'b00;
        stk_d       = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    req_ready   = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_RESP;
                if (w_stk_go) begin
                    stk_en = 1'b1;
                    stk_op = r_cmd_op;
                    stk_d  = (r_cmd_op == OP_PUSH) ? r_cmd_data : '0;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                rsp_valid   = r_cmd_id ? 2'b10 : 2'b01;
                rsp_data    = r_rsp_data;
                rsp_err     = r_rsp_err;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pop captures the pre-shift top in the same cycle the stack is told to shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cmd_op     <= 2'b00;
            r_cmd_data   <= '0;
            r_cmd_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_win;
                r_cmd_op     <= w_win_op;
                r_cmd_data   <= w_win_data;
                r_cmd_id     <= w_win;
            end
            if (r_state == S_ISSUE) begin
                r_rsp_err  <= w_err;
                r_rsp_data <= w_capture ? stk_top : '0;
            end
        end
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one shift-register stack (LIFO, top at q[0], stack pointer sp) between two requesters. Requesters submit push/pop/peek commands over a valid/ready handshake. A round-robin arbiter grants one command at a time, and a three-state FSM sequences the stack. Each command gets exactly one response beat with data and an error flag. The block sits between the requesters and the stack instance and is the only agent allowed to drive the stack's d/op inputs.

## Interface
- DATA_WIDTH, 8, width of stack entries and request/response data
- STACK_DEPTH, 16, number of stack entries (matches the stack instance)
- ADDR_WIDTH, $clog2(STACK_DEPTH), width of the stack pointer
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  2  per-requester command valid; bit i = requester i
- req_op  input  4  per-requester opcode, bits [2i+1:2i]: 01 push, 10 pop, 11 peek, 00 illegal
- req_data  input  2*DATA_WIDTH  per-requester push data, bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- req_ready  output  2  one-hot accept pulse; handshake completes when valid&ready
- rsp_valid  output  2  one-hot, one-cycle response strobe to the owning requester
- rsp_data  output  DATA_WIDTH  popped/peeked value; 0 for push and on error
- rsp_err  output  1  qualifies rsp_valid; 1 = command rejected
- busy  output  1  high whenever the FSM is not IDLE
- stk_en  output  1  stack command strobe; the stack must advance only when it is 1
- stk_op  output  2  stack opcode: 01 push, 10 pop
- stk_d  output  DATA_WIDTH  push data to the stack
- stk_top  input  DATA_WIDTH  stack q[0]
- stk_full  input  1  stack full (sp == STACK_DEPTH-1)
- stk_empty  input  1  stack empty (sp == 0)

## Operation
- FSM states:
  - IDLE → ISSUE when any req_valid is high.
  - ISSUE → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only:
  - One requester valid: it wins.
  - Both valid: the requester that is not last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Grant: in IDLE, req_ready[w] is asserted combinationally for the winner. op/data/id are latched into cmd registers on that edge.
- Requester rules: a requester must hold req_valid, req_op and req_data stable until ready. A requester not granted sees req_ready=0 and keeps waiting; no command is dropped.
- ISSUE, per opcode:
  - push: stk_full=1 gives err, no stack access. Otherwise stk_en=1, stk_op=01, stk_d=cmd_data.
  - pop: stk_empty=1 gives err. Otherwise stk_en=1, stk_op=10, and stk_top is captured into the response register in the same cycle (pre-shift value).
  - peek: stk_empty=1 gives err. Otherwise stk_top is captured with stk_en=0. The stack is unchanged.
  - 00: err, no stack access.
- RESP: rsp_valid[cmd_id]=1 for exactly one cycle with rsp_data and rsp_err. rsp_data is 0 when rsp_err=1 or for push.
- stk_en is high only in ISSUE, and only for a legal non-error push/pop. stk_op/stk_d are 0 whenever stk_en=0.
- Full/empty checks use the stack's live flags sampled in ISSUE. The arbiter keeps no shadow sp.

## Timing
- Reset values: state IDLE, last_grant=1, cmd registers 0. All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, busy, stk_en, stk_op, stk_d.
- Cycle T: IDLE, req_ready[w]=1 (accept).
- Cycle T+1: ISSUE, stack command; the stack updates at the end of T+1.
- Cycle T+2: RESP, rsp_valid. Cycle T+3: IDLE, so the next accept is at the earliest at T+3.
- Latency from accept to response: 2 cycles. Peak throughput: one command per 3 cycles.
- Back-to-back with both requesters valid continuously: grants strictly alternate 0,1,0,1.
- Flag timing: stk_full/stk_empty seen in ISSUE reflect all previously issued commands, since the previous stack update landed at the end of the prior ISSUE at least 2 cycles earlier.
- Reset mid-operation: an in-flight command is abandoned with no response. stk_en drops immediately (asynchronous).

## Test plan
- Reset, then req0 push 0xA5 → ready[0] at T, stk_en/op=01/d=0xA5 at T+1, rsp_valid=01 with err=0 at T+2; the stack then holds sp=1 and q[0]=0xA5.
- Push 0x11 then 0x22, then req1 pop ×2 → rsp_data 0x22 then 0x11, err=0. A third pop → rsp_err=1, rsp_data=0, stk_en never asserted.
- Fill to stk_full (STACK_DEPTH-1 pushes), then push 0x33 → err=1, no stk_en; a following peek → 0xFF-pattern last pushed value with err=0 and sp unchanged.
- Both requesters valid continuously from reset with push ops → grants 0,1,0,1; each req_ready followed by its rsp_valid 2 cycles later; busy low only on accept cycles.
- req_op=00 from req1 → err=1 response, no stack access; then assert rst_n=0 during ISSUE of a push → all outputs 0 immediately, no rsp_valid after release.
